// File: rtl/csr_pkg.sv
// Shared constants, types and helpers for the WB-stage CSR file.
// The timer CSRs behind these addresses exist only when CSR_TIMER_EN is defined.
package csr_pkg;

    localparam logic [13:0] CSR_CRMD   = 14'h0;
    localparam logic [13:0] CSR_PRMD   = 14'h1;
    localparam logic [13:0] CSR_ECFG   = 14'h4;
    localparam logic [13:0] CSR_ESTAT  = 14'h5;
    localparam logic [13:0] CSR_ERA    = 14'h6;
    localparam logic [13:0] CSR_BADV   = 14'h7;
    localparam logic [13:0] CSR_EENTRY = 14'hC;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    localparam int NUM_SAVE = 4;

    localparam logic [31:0] CRMD_WMASK   = 32'h0000_01FF;
    localparam logic [31:0] PRMD_WMASK   = 32'h0000_0007;
    localparam logic [31:0] ECFG_WMASK   = 32'h0000_1BFF;
    localparam logic [31:0] ESTAT_WMASK  = 32'h0000_0003;
    localparam logic [31:0] EENTRY_WMASK = 32'hFFFF_FFC0;
    localparam logic [31:0] TCFG_WMASK   = 32'hFFFF_FFFF;
    localparam logic [31:0] FULL_WMASK   = 32'hFFFF_FFFF;

    localparam logic [31:0] CRMD_RESET = 32'h0000_0008;
    localparam logic [31:0] TVAL_RESET = 32'hFFFF_FFFF;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;

    localparam int CRMD_PLV_LSB     = 0;
    localparam int CRMD_IE_BIT      = 2;
    localparam int PRMD_PPLV_LSB    = 0;
    localparam int PRMD_PIE_BIT     = 2;
    localparam int ESTAT_IS_HWI_LSB = 2;
    localparam int ESTAT_IS_TI_BIT  = 11;
    localparam int ESTAT_IS_IPI_BIT = 12;
    localparam int ESTAT_IS_W       = 13;
    localparam int ESTAT_ECODE_LSB  = 16;
    localparam int ESTAT_ESUB_LSB   = 22;
    localparam int TCFG_EN_BIT      = 0;
    localparam int TCFG_PER_BIT     = 1;

    typedef struct packed {
        logic [13:0] addr;
        logic [31:0] we;
        logic [31:0] wdata;
    } csr_wr_t;

    function automatic logic csr_hit(input csr_wr_t w, input logic [13:0] a);
        return (|w.we) && (w.addr == a);
    endfunction

    // Bit-masked merge of software data, then clipped to the writable bits.
    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input csr_wr_t     w,
                                              input logic [31:0] wmask);
        return ((old_val & ~w.we) | (w.wdata & w.we)) & wmask;
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Stable timer: owns TCFG/TVAL, counts down and flags expiry for ESTAT.IS[11].
// Instantiated by csr_file only when CSR_TIMER_EN is defined.
module csr_timer
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        tcfg_wr,
    input  logic [31:0] we,
    input  logic [31:0] wdata,
    output logic [31:0] tcfg,
    output logic [31:0] tval,
    output logic        timer_int_set
);

    logic [31:0] tcfg_q, tcfg_d;
    logic [31:0] tval_q, tval_d;
    csr_wr_t     wr;

    assign wr = '{addr: CSR_TCFG, we: we, wdata: wdata};

    always_comb begin
        tcfg_d        = tcfg_q;
        tval_d        = tval_q;
        timer_int_set = 1'b0;
        if (tcfg_wr) begin
            tcfg_d = csr_merge(tcfg_q, wr, TCFG_WMASK);
            tval_d = {tcfg_d[31:2], 2'b00};
        end else if (tcfg_q[TCFG_EN_BIT]) begin
            if (tval_q == 32'h0) begin
                timer_int_set = 1'b1;
                tval_d = tcfg_q[TCFG_PER_BIT] ? {tcfg_q[31:2], 2'b00} : TVAL_RESET;
            end else if (tcfg_q[TCFG_PER_BIT] || (tval_q != TVAL_RESET)) begin
                // A spent one-shot parks at all-ones instead of wrapping around.
                tval_d = tval_q - 32'h1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tcfg_q <= '0;
            tval_q <= TVAL_RESET;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
        end
    end

    assign tcfg = tcfg_q;
    assign tval = tval_q;

endmodule

// File: rtl/csr_file.sv
// WB-stage CSR file: architectural CSRs, exception/ERTN state swap, interrupt request.
// Define CSR_TIMER_EN to build TID/TCFG/TVAL/TICLR and the stable timer.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] TID_RESET = 32'h0,
    parameter int          HWI_W     = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [13:0]      csr_raddr,
    output logic [31:0]      csr_rdata,
    input  logic [13:0]      WB_csr_waddr,
    input  logic [31:0]      WB_csr_we,
    input  logic [31:0]      WB_csr_wdata,
    input  logic             WB_ertn,
    input  logic [6:0]       WB_ecode_in,
    input  logic             WB_ecode_we,
    input  logic [31:0]      WB_badv_in,
    input  logic             WB_badv_we,
    input  logic [31:0]      WB_era_in,
    input  logic             WB_era_we,
    input  logic             WB_store_state,
    input  logic             WB_restore_state,
    input  logic [HWI_W-1:0] hw_int,
    input  logic             ipi,
    output logic [31:0]      eentry_pc,
    output logic [31:0]      era_pc,
    output logic [1:0]       plv,
    output logic             int_pending
);

    csr_wr_t sw_wr;
    assign sw_wr = '{addr: WB_csr_waddr, we: WB_csr_we, wdata: WB_csr_wdata};

    logic [31:0] crmd_q, crmd_d;
    logic [31:0] prmd_q, prmd_d;
    logic [31:0] ecfg_q, ecfg_d;
    logic [31:0] estat_q, estat_d;
    logic [31:0] era_q, era_d;
    logic [31:0] badv_q, badv_d;
    logic [31:0] eentry_q, eentry_d;
    logic [31:0] save_q [NUM_SAVE];
    logic [31:0] save_d [NUM_SAVE];
    logic        int_pending_q, int_pending_d;
    logic [NUM_SAVE-1:0] wr_save;
    logic        restore;
    logic        ti_next;

    for (genvar gi = 0; gi < NUM_SAVE; gi++) begin : g_save_hit
        assign wr_save[gi] = csr_hit(sw_wr, CSR_SAVE0 + 14'(gi));
    end

    assign restore = WB_restore_state | WB_ertn;

`ifdef CSR_TIMER_EN
    logic [31:0] tcfg, tval;
    logic [31:0] tid_q, tid_d;
    logic        timer_int_set;
    logic        wr_tcfg;
    logic        ticlr_clr;

    assign wr_tcfg   = csr_hit(sw_wr, CSR_TCFG);
    assign ticlr_clr = csr_hit(sw_wr, CSR_TICLR) & WB_csr_we[0] & WB_csr_wdata[0];

    csr_timer u_timer (
        .clk           (clk),
        .rstn          (rstn),
        .tcfg_wr       (wr_tcfg),
        .we            (WB_csr_we),
        .wdata         (WB_csr_wdata),
        .tcfg          (tcfg),
        .tval          (tval),
        .timer_int_set (timer_int_set)
    );

    always_comb begin
        tid_d = tid_q;
        if (csr_hit(sw_wr, CSR_TID)) begin
            tid_d = csr_merge(tid_q, sw_wr, FULL_WMASK);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tid_q <= TID_RESET;
        end else begin
            tid_q <= tid_d;
        end
    end

    // A software clear beats a timer expiry landing on the same edge.
    assign ti_next = ticlr_clr ? 1'b0 :
                     (timer_int_set ? 1'b1 : estat_q[ESTAT_IS_TI_BIT]);
`else
    assign ti_next = 1'b0;
`endif

    always_comb begin
        crmd_d = crmd_q;
        prmd_d = prmd_q;
        if (csr_hit(sw_wr, CSR_CRMD)) begin
            crmd_d = csr_merge(crmd_q, sw_wr, CRMD_WMASK);
        end
        if (csr_hit(sw_wr, CSR_PRMD)) begin
            prmd_d = csr_merge(prmd_q, sw_wr, PRMD_WMASK);
        end
        // Exception entry outranks both ERTN and software writes to these fields.
        if (WB_store_state) begin
            prmd_d[PRMD_PPLV_LSB +: 2] = crmd_q[CRMD_PLV_LSB +: 2];
            prmd_d[PRMD_PIE_BIT]       = crmd_q[CRMD_IE_BIT];
            crmd_d[CRMD_PLV_LSB +: 2]  = 2'b00;
            crmd_d[CRMD_IE_BIT]        = 1'b0;
        end else if (restore) begin
            crmd_d[CRMD_PLV_LSB +: 2]  = prmd_q[PRMD_PPLV_LSB +: 2];
            crmd_d[CRMD_IE_BIT]        = prmd_q[PRMD_PIE_BIT];
        end
    end

    always_comb begin
        ecfg_d   = ecfg_q;
        eentry_d = eentry_q;
        era_d    = era_q;
        badv_d   = badv_q;
        if (csr_hit(sw_wr, CSR_ECFG)) begin
            ecfg_d = csr_merge(ecfg_q, sw_wr, ECFG_WMASK);
        end
        if (csr_hit(sw_wr, CSR_EENTRY)) begin
            eentry_d = csr_merge(eentry_q, sw_wr, EENTRY_WMASK);
        end
        if (csr_hit(sw_wr, CSR_ERA)) begin
            era_d = csr_merge(era_q, sw_wr, FULL_WMASK);
        end
        if (csr_hit(sw_wr, CSR_BADV)) begin
            badv_d = csr_merge(badv_q, sw_wr, FULL_WMASK);
        end
        if (WB_era_we) begin
            era_d = WB_era_in;
        end
        if (WB_badv_we) begin
            badv_d = WB_badv_in;
        end
        for (int i = 0; i < NUM_SAVE; i++) begin
            save_d[i] = wr_save[i] ? csr_merge(save_q[i], sw_wr, FULL_WMASK) : save_q[i];
        end
    end

    always_comb begin
        estat_d = estat_q;
        if (csr_hit(sw_wr, CSR_ESTAT)) begin
            estat_d = (estat_q & ~ESTAT_WMASK) | csr_merge(estat_q, sw_wr, ESTAT_WMASK);
        end
        estat_d[ESTAT_IS_HWI_LSB +: HWI_W] = hw_int;
        estat_d[ESTAT_IS_IPI_BIT]          = ipi;
        estat_d[ESTAT_IS_TI_BIT]           = ti_next;
        if (WB_ecode_we) begin
            estat_d[ESTAT_ECODE_LSB +: 6] = WB_ecode_in[5:0];
            estat_d[ESTAT_ESUB_LSB +: 9]  = {8'b0, WB_ecode_in[6]};
        end
    end

    assign int_pending_d = crmd_q[CRMD_IE_BIT] &
                           (|(estat_q[ESTAT_IS_W-1:0] & ecfg_q[ESTAT_IS_W-1:0]));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            crmd_q        <= CRMD_RESET;
            prmd_q        <= '0;
            ecfg_q        <= '0;
            estat_q       <= '0;
            era_q         <= '0;
            badv_q        <= '0;
            eentry_q      <= '0;
            int_pending_q <= 1'b0;
            for (int i = 0; i < NUM_SAVE; i++) begin
                save_q[i] <= '0;
            end
        end else begin
            crmd_q        <= crmd_d;
            prmd_q        <= prmd_d;
            ecfg_q        <= ecfg_d;
            estat_q       <= estat_d;
            era_q         <= era_d;
            badv_q        <= badv_d;
            eentry_q      <= eentry_d;
            int_pending_q <= int_pending_d;
            for (int i = 0; i < NUM_SAVE; i++) begin
                save_q[i] <= save_d[i];
            end
        end
    end

    always_comb begin
        csr_rdata = '0;
        case (csr_raddr)
            CSR_CRMD:          csr_rdata = crmd_q;
            CSR_PRMD:          csr_rdata = prmd_q;
            CSR_ECFG:          csr_rdata = ecfg_q;
            CSR_ESTAT:         csr_rdata = estat_q;
            CSR_ERA:           csr_rdata = era_q;
            CSR_BADV:          csr_rdata = badv_q;
            CSR_EENTRY:        csr_rdata = eentry_q;
            CSR_SAVE0:         csr_rdata = save_q[0];
            CSR_SAVE0 + 14'd1: csr_rdata = save_q[1];
            CSR_SAVE0 + 14'd2: csr_rdata = save_q[2];
            CSR_SAVE0 + 14'd3: csr_rdata = save_q[3];
`ifdef CSR_TIMER_EN
            CSR_TID:           csr_rdata = tid_q;
            CSR_TCFG:          csr_rdata = tcfg;
            CSR_TVAL:          csr_rdata = tval;
`endif
            default:           csr_rdata = '0;
        endcase
    end

    assign eentry_pc   = eentry_q;
    assign era_pc      = era_q;
    assign plv         = crmd_q[CRMD_PLV_LSB +: 2];
    assign int_pending = int_pending_q;

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: directed scenarios then random traffic against a CSR model.
// Timer expectations follow whether CSR_TIMER_EN is defined for the build.
module tb_csr_file;

`ifdef CSR_TIMER_EN
    localparam bit TIMER = 1'b1;
`else
    localparam bit TIMER = 1'b0;
`endif

    localparam logic [13:0] A_CRMD = 14'h0, A_PRMD = 14'h1, A_ECFG = 14'h4, A_ESTAT = 14'h5;
    localparam logic [13:0] A_ERA = 14'h6, A_BADV = 14'h7, A_EENTRY = 14'hC;
    localparam logic [13:0] A_SAVE0 = 14'h30, A_SAVE1 = 14'h31, A_SAVE2 = 14'h32, A_SAVE3 = 14'h33;
    localparam logic [13:0] A_TID = 14'h40, A_TCFG = 14'h41, A_TVAL = 14'h42, A_TICLR = 14'h44;

    logic        clk = 1'b0;
    logic        rstn;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic [13:0] WB_csr_waddr;
    logic [31:0] WB_csr_we, WB_csr_wdata;
    logic        WB_ertn, WB_ecode_we, WB_badv_we, WB_era_we, WB_store_state, WB_restore_state;
    logic [6:0]  WB_ecode_in;
    logic [31:0] WB_badv_in, WB_era_in;
    logic [7:0]  hw_int;
    logic        ipi;
    logic [31:0] eentry_pc, era_pc;
    logic [1:0]  plv;
    logic        int_pending;

    csr_file #(.TID_RESET(32'h0), .HWI_W(8)) dut (
        .clk(clk), .rstn(rstn), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .WB_csr_waddr(WB_csr_waddr), .WB_csr_we(WB_csr_we), .WB_csr_wdata(WB_csr_wdata),
        .WB_ertn(WB_ertn), .WB_ecode_in(WB_ecode_in), .WB_ecode_we(WB_ecode_we),
        .WB_badv_in(WB_badv_in), .WB_badv_we(WB_badv_we), .WB_era_in(WB_era_in),
        .WB_era_we(WB_era_we), .WB_store_state(WB_store_state),
        .WB_restore_state(WB_restore_state), .hw_int(hw_int), .ipi(ipi),
        .eentry_pc(eentry_pc), .era_pc(era_pc), .plv(plv), .int_pending(int_pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] addr;
        logic [31:0] rdata;
        logic [1:0]  plv;
        logic [31:0] era;
        logic [31:0] eentry;
        logic        ip;
        bit          hc;
        logic [31:0] cv;
    } item_t;

    item_t sbq[$];
    int checks = 0;
    int errors = 0;
    int txn = 0;

    // Reference model: every implemented CSR is a key; absent keys read as zero.
    logic [31:0] m_csr [logic [13:0]];
    logic        m_ip;

    function automatic logic [31:0] wmask(input logic [13:0] a);
        case (a)
            A_CRMD:   return 32'h1FF;
            A_PRMD:   return 32'h7;
            A_ECFG:   return 32'h1BFF;
            A_ESTAT:  return 32'h3;
            A_EENTRY: return 32'hFFFF_FFC0;
            A_TVAL:   return 32'h0;
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [13:0] a);
        return m_csr.exists(a) ? m_csr[a] : 32'h0;
    endfunction

    task automatic model_reset();
        m_csr.delete();
        m_csr[A_CRMD] = 32'h8;
        m_csr[A_PRMD] = 0; m_csr[A_ECFG] = 0; m_csr[A_ESTAT] = 0; m_csr[A_ERA] = 0;
        m_csr[A_BADV] = 0; m_csr[A_EENTRY] = 0;
        m_csr[A_SAVE0] = 0; m_csr[A_SAVE1] = 0; m_csr[A_SAVE2] = 0; m_csr[A_SAVE3] = 0;
        if (TIMER) begin
            m_csr[A_TID] = 0; m_csr[A_TCFG] = 0; m_csr[A_TVAL] = 32'hFFFF_FFFF;
        end
        m_ip = 1'b0;
    endtask

    task automatic model_step();
        logic [31:0] old [logic [13:0]];
        logic [31:0] o_crmd, o_prmd, o_estat, o_ecfg, o_tcfg, o_tval, merged, m, e, c, p;
        bit fire, clr, tcfg_wr;
        if (!rstn) begin
            model_reset();
            return;
        end
        old = m_csr;
        o_crmd = old[A_CRMD]; o_prmd = old[A_PRMD]; o_estat = old[A_ESTAT]; o_ecfg = old[A_ECFG];
        o_tcfg = TIMER ? old[A_TCFG] : 32'h0;
        o_tval = TIMER ? old[A_TVAL] : 32'h0;
        fire = 0; clr = 0; tcfg_wr = 0;
        if (WB_csr_we != 0 && m_csr.exists(WB_csr_waddr)) begin
            merged = (old[WB_csr_waddr] & ~WB_csr_we) | (WB_csr_wdata & WB_csr_we);
            m = wmask(WB_csr_waddr);
            m_csr[WB_csr_waddr] = (old[WB_csr_waddr] & ~m) | (merged & m);
            if (WB_csr_waddr == A_TCFG) begin
                tcfg_wr = 1;
                m_csr[A_TVAL] = m_csr[A_TCFG] & ~32'h3;
            end
        end
        if (TIMER && WB_csr_waddr == A_TICLR && (WB_csr_we & WB_csr_wdata & 32'h1) != 0) clr = 1;
        if (TIMER && !tcfg_wr && o_tcfg[0]) begin
            if (o_tval == 0) begin
                fire = 1;
                m_csr[A_TVAL] = o_tcfg[1] ? (o_tcfg & ~32'h3) : 32'hFFFF_FFFF;
            end else if (o_tcfg[1] || o_tval != 32'hFFFF_FFFF) begin
                m_csr[A_TVAL] = o_tval - 1;
            end
        end
        e = m_csr[A_ESTAT];
        e[9:2] = hw_int;
        e[12] = ipi;
        e[11] = clr ? 1'b0 : (fire ? 1'b1 : o_estat[11]);
        if (WB_ecode_we) begin
            e[21:16] = WB_ecode_in[5:0];
            e[30:22] = {8'b0, WB_ecode_in[6]};
        end
        m_csr[A_ESTAT] = e;
        if (WB_era_we) m_csr[A_ERA] = WB_era_in;
        if (WB_badv_we) m_csr[A_BADV] = WB_badv_in;
        c = m_csr[A_CRMD];
        p = m_csr[A_PRMD];
        if (WB_store_state) begin
            p[2:0] = o_crmd[2:0];
            c[2:0] = 3'b000;
        end else if (WB_restore_state || WB_ertn) begin
            c[2:0] = o_prmd[2:0];
        end
        m_csr[A_CRMD] = c;
        m_csr[A_PRMD] = p;
        m_ip = o_crmd[2] && ((o_estat & o_ecfg & 32'h1FFF) != 0);
    endtask

    task automatic idle();
        WB_csr_waddr = 0; WB_csr_we = 0; WB_csr_wdata = 0;
        WB_ertn = 0; WB_ecode_in = 0; WB_ecode_we = 0; WB_badv_in = 0; WB_badv_we = 0;
        WB_era_in = 0; WB_era_we = 0; WB_store_state = 0; WB_restore_state = 0;
        hw_int = 0; ipi = 0;
    endtask

    task automatic set_wr(input logic [13:0] a, input logic [31:0] we, input logic [31:0] wd);
        WB_csr_waddr = a; WB_csr_we = we; WB_csr_wdata = wd;
    endtask

    // Push the expected view for this cycle, then advance the model across the edge.
    task automatic issue(input logic [13:0] ra, input bit hc, input logic [31:0] cv);
        item_t it;
        logic [31:0] c;
        csr_raddr = ra;
        c = m_csr[A_CRMD];
        it.addr = ra; it.rdata = mread(ra); it.plv = c[1:0];
        it.era = m_csr[A_ERA]; it.eentry = m_csr[A_EENTRY]; it.ip = m_ip;
        it.hc = hc; it.cv = cv;
        sbq.push_back(it);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string nm, input logic [13:0] a, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s addr=%h got=%h expected=%h", nm, a, act, exp);
        end
    endtask

    initial begin : monitor
        item_t mi;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                mi = sbq.pop_front();
                txn++;
                chk("rdata", mi.addr, csr_rdata, mi.rdata);
                if (mi.hc) chk("rdata_const", mi.addr, csr_rdata, mi.cv);
                chk("plv", mi.addr, {30'b0, plv}, {30'b0, mi.plv});
                chk("era_pc", mi.addr, era_pc, mi.era);
                chk("eentry_pc", mi.addr, eentry_pc, mi.eentry);
                chk("int_pending", mi.addr, {31'b0, int_pending}, {31'b0, mi.ip});
                $display("txn %0d raddr=%h rdata=%h plv=%0d ip=%b", txn, mi.addr, csr_rdata, plv, int_pending);
            end
        end
    end

    logic [13:0] addr_pool [18] = '{A_CRMD, A_PRMD, A_ECFG, A_ESTAT, A_ERA, A_BADV, A_EENTRY,
                                    A_SAVE0, A_SAVE1, A_SAVE2, A_SAVE3, A_TID, A_TCFG, A_TVAL,
                                    A_TICLR, 14'h2, 14'h43, 14'h3FFF};

    initial begin : stim
        rstn = 1'b0;
        idle();
        csr_raddr = 0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;
        rstn = 1'b1;

        issue(A_CRMD, 1, 32'h8);
        issue(A_TVAL, 1, TIMER ? 32'hFFFF_FFFF : 32'h0);

        set_wr(A_CRMD, 32'h7, 32'hFFFF_FFF7);
        issue(A_CRMD, 1, 32'h8);
        idle();
        issue(A_CRMD, 1, 32'hF);

        WB_store_state = 1; WB_ecode_we = 1; WB_ecode_in = 7'h0B;
        WB_era_we = 1; WB_era_in = 32'h1C00_0100;
        issue(A_CRMD, 1, 32'hF);
        idle();
        issue(A_PRMD, 1, 32'h7);
        issue(A_CRMD, 1, 32'h8);
        issue(A_ESTAT, 1, 32'h000B_0000);
        issue(A_ERA, 1, 32'h1C00_0100);
        WB_restore_state = 1;
        issue(A_CRMD, 1, 32'h8);
        idle();
        issue(A_CRMD, 1, 32'hF);

`ifdef CSR_TIMER_EN
        set_wr(A_TCFG, 32'hFFFF_FFFF, 32'h13);
        issue(A_TCFG, 0, 0);
        idle();
        for (int k = 0; k <= 16; k++) issue(A_TVAL, 1, 32'h10 - 32'(k));
        issue(A_TVAL, 1, 32'h10);
        issue(A_ESTAT, 1, 32'h000B_0800);
        set_wr(A_TICLR, 32'h1, 32'h1);
        issue(A_ESTAT, 1, 32'h000B_0800);
        idle();
        issue(A_ESTAT, 1, 32'h000B_0000);

        set_wr(A_ECFG, 32'hFFFF_FFFF, 32'h800);
        issue(A_ECFG, 0, 0);
        idle();
        repeat (20) issue(A_ESTAT, 0, 0);
        set_wr(A_CRMD, 32'h4, 32'h0);
        issue(A_CRMD, 0, 0);
        idle();
        repeat (3) issue(A_ESTAT, 0, 0);
        set_wr(A_TCFG, 32'hFFFF_FFFF, 32'h0);
        issue(A_TCFG, 0, 0);
        set_wr(A_TICLR, 32'h1, 32'h1);
        issue(A_ESTAT, 0, 0);
        idle();
`endif

        set_wr(A_CRMD, 32'h4, 32'h4);
        issue(A_CRMD, 0, 0);
        set_wr(A_ECFG, 32'hFFFF_FFFF, 32'h4);
        hw_int = 8'h01;
        issue(A_ESTAT, 0, 0);
        WB_csr_we = 0;
        issue(A_ESTAT, 1, 32'h000B_0004);
        issue(A_ECFG, 1, 32'h4);
        issue(A_ESTAT, 0, 0);
        idle();

`ifdef CSR_TIMER_EN
        set_wr(A_TCFG, 32'hFFFF_FFFF, 32'h101);
        issue(A_TCFG, 0, 0);
        idle();
        repeat (5) issue(A_TVAL, 0, 0);
`endif
        rstn = 1'b0;
        issue(A_CRMD, 0, 0);
        rstn = 1'b1;
        issue(A_CRMD, 1, 32'h8);
        issue(A_TVAL, 1, TIMER ? 32'hFFFF_FFFF : 32'h0);
        issue(A_ESTAT, 1, 32'h0);
        issue(A_ERA, 1, 32'h0);
        issue(A_PRMD, 1, 32'h0);
        issue(A_ECFG, 1, 32'h0);

        for (int n = 0; n < 1500; n++) begin
            int r;
            rstn = ($urandom_range(0, 199) != 0);
            WB_csr_waddr = addr_pool[$urandom_range(0, 17)];
            r = $urandom_range(0, 3);
            WB_csr_we = (r == 0) ? 32'h0 : (r == 1) ? 32'hFFFF_FFFF : $urandom;
            WB_csr_wdata = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 63));
            if (WB_csr_waddr == A_TCFG) WB_csr_wdata = 32'($urandom_range(0, 40));
            WB_ertn = ($urandom_range(0, 15) == 0);
            WB_store_state = ($urandom_range(0, 15) == 0);
            WB_restore_state = ($urandom_range(0, 15) == 0);
            WB_ecode_we = ($urandom_range(0, 7) == 0);
            WB_ecode_in = 7'($urandom);
            WB_badv_we = ($urandom_range(0, 7) == 0);
            WB_badv_in = $urandom;
            WB_era_we = ($urandom_range(0, 7) == 0);
            WB_era_in = $urandom;
            if ($urandom_range(0, 7) == 0) hw_int = 8'($urandom);
            if ($urandom_range(0, 7) == 0) ipi = 1'($urandom);
            issue(addr_pool[$urandom_range(0, 17)], 0, 0);
        end

        idle();
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
